// File: rtl/xpb_accum_if.sv
// Bundle of the term stream, start/base load and result handshake for xpb_accum_seq.
// The master drives start, base_in, the term stream and sum_ack; the slave is the accumulator.
interface xpb_accum_if #(
    parameter int DATA_W = 1024,
    parameter int CNT_W  = 6,
    parameter int SUM_W  = DATA_W + 6
);
    logic              start;
    logic [DATA_W-1:0] base_in;
    logic              term_valid;
    logic [DATA_W-1:0] term_in;
    logic              term_last;
    logic              term_ready;
    logic              busy;
    logic              sum_valid;
    logic [SUM_W-1:0]  sum_out;
    logic              sum_ack;
    logic [CNT_W-1:0]  term_count;
    logic              count_err;

    modport master (
        output start, base_in, term_valid, term_in, term_last, sum_ack,
        input  term_ready, busy, sum_valid, sum_out, term_count, count_err
    );

    modport slave (
        input  start, base_in, term_valid, term_in, term_last, sum_ack,
        output term_ready, busy, sum_valid, sum_out, term_count, count_err
    );
endinterface

// File: rtl/xpb_accum_seq.sv
// Carry-save accumulator for XPB table outputs: loads a base, absorbs one term per cycle,
// resolves S+C with a single carry-propagate add and offers the widened sum to the next stage.
module xpb_accum_seq #(
    parameter int DATA_W    = 1024,
    parameter int NUM_TERMS = 32,
    parameter int CNT_W     = 6,
    parameter int SUM_W     = DATA_W + 6
) (
    input  logic        clk,
    input  logic        rst_n,
    xpb_accum_if.slave  bus,
    output logic [1:0]  state_dbg
);

    // Handshakes: a term transfers on a rising edge where term_valid && term_ready;
    // the result transfers on a rising edge where sum_valid && sum_ack. Neither side
    // may make its valid depend combinationally on the other side's ready/ack.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_TERMS);

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  s_q, s_d;
    logic [SUM_W-1:0]  c_q, c_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [SUM_W-1:0]  term_ext;
    logic [SUM_W-1:0]  base_ext;
    logic [CNT_W-1:0]  cnt_inc;

    assign term_ext = {{(SUM_W-DATA_W){1'b0}}, bus.term_in};
    assign base_ext = {{(SUM_W-DATA_W){1'b0}}, bus.base_in};
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    s_d     = base_ext;
                    c_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.term_valid) begin
                    // 3:2 compression; the shifted carry never overflows SUM_W by construction
                    s_d   = s_q ^ c_q ^ term_ext;
                    c_d   = ((s_q & c_q) | (s_q & term_ext) | (c_q & term_ext)) << 1;
                    cnt_d = cnt_inc;
                    if (bus.term_last) begin
                        state_d = RESOLVE;
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d = RESOLVE;
                        err_d   = 1'b1;
                    end
                end
            end
            RESOLVE: begin
                sum_d   = s_q + c_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.sum_ack) begin
                    if (bus.start) begin
                        s_d     = base_ext;
                        c_d     = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.term_ready = (state_q == ACCUM);
    assign bus.busy       = (state_q != IDLE);
    assign bus.sum_valid  = (state_q == DONE);
    assign bus.sum_out    = sum_q;
    assign bus.term_count = cnt_q;
    assign bus.count_err  = err_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Randomized self-checking bench for xpb_accum_seq against an arithmetic reference model.
module tb_xpb_accum_seq;
    localparam int DATA_W    = 1024;
    localparam int NUM_TERMS = 32;
    localparam int CNT_W     = 6;
    localparam int SUM_W     = DATA_W + 6;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    xpb_accum_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();

    xpb_accum_seq #(
        .DATA_W(DATA_W), .NUM_TERMS(NUM_TERMS), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: one entry per operation the model expects to complete
    logic [SUM_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];
    logic             exp_err_q[$];

    // reference model: an operation is base plus plain integer sum of its terms
    logic             model_open;
    logic [SUM_W-1:0] model_sum;
    int               model_cnt;
    logic [SUM_W-1:0] last_exp;

    task automatic check(input string tag, input logic [SUM_W-1:0] got, input logic [SUM_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got hi=%0h lo=%0h, expected hi=%0h lo=%0h", tag,
                     got[SUM_W-1:SUM_W-16], got[127:0], exp[SUM_W-1:SUM_W-16], exp[127:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_start(input logic [DATA_W-1:0] base);
        model_open = 1'b1;
        model_sum  = SUM_W'(base);
        model_cnt  = 0;
    endtask

    task automatic model_term(input logic [DATA_W-1:0] val, input logic last);
        if (model_open) begin
            model_sum = model_sum + SUM_W'(val);
            model_cnt++;
            if (last || model_cnt == NUM_TERMS) begin
                exp_q.push_back(model_sum);
                exp_cnt_q.push_back(CNT_W'(model_cnt));
                exp_err_q.push_back(!last);
                model_open = 1'b0;
            end
        end
    endtask

    // driver tasks
    task automatic do_start(input logic [DATA_W-1:0] base);
        bus.start   = 1'b1;
        bus.base_in = base;
        model_start(base);
        step();
        bus.start = 1'b0;
        check("term_ready_after_start", SUM_W'(bus.term_ready), 1);
    endtask

    task automatic send_term(input logic [DATA_W-1:0] val, input logic last);
        check("term_ready_before_term", SUM_W'(bus.term_ready), SUM_W'(model_open));
        bus.term_valid = 1'b1;
        bus.term_in    = val;
        bus.term_last  = last;
        step();
        model_term(val, last);
        bus.term_valid = 1'b0;
        bus.term_last  = 1'b0;
    endtask

    task automatic wait_sum(input string tag);
        int guard;
        guard = 0;
        while (!bus.sum_valid && guard < 40) begin
            step();
            guard++;
        end
        check({tag, "_sum_valid"}, SUM_W'(bus.sum_valid), 1);
        check({tag, "_exp_pending"}, SUM_W'(exp_q.size() != 0), 1);
        if (bus.sum_valid && exp_q.size() != 0) begin
            last_exp = exp_q.pop_front();
            check({tag, "_sum_out"}, bus.sum_out, last_exp);
            check({tag, "_term_count"}, SUM_W'(bus.term_count), SUM_W'(exp_cnt_q.pop_front()));
            check({tag, "_count_err"}, SUM_W'(bus.count_err), SUM_W'(exp_err_q.pop_front()));
        end
    endtask

    task automatic ack_sum();
        bus.sum_ack = 1'b1;
        step();
        bus.sum_ack = 1'b0;
        check("sum_valid_after_ack", SUM_W'(bus.sum_valid), 0);
        check("busy_after_ack", SUM_W'(bus.busy), 0);
    endtask

    function automatic logic [DATA_W-1:0] rand_term();
        logic [DATA_W-1:0] v;
        for (int w = 0; w < DATA_W / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    logic [DATA_W-1:0] full_term;
    logic [SUM_W-1:0]  full_exp;
    logic [DATA_W-1:0] b4;

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_in    = '0;
        bus.term_valid = 1'b0;
        bus.term_in    = '0;
        bus.term_last  = 1'b0;
        bus.sum_ack    = 1'b0;
        model_open     = 1'b0;
        model_sum      = '0;
        model_cnt      = 0;
        last_exp       = '0;
        idle(3);
        check("rst_term_ready", SUM_W'(bus.term_ready), 0);
        check("rst_busy", SUM_W'(bus.busy), 0);
        check("rst_sum_valid", SUM_W'(bus.sum_valid), 0);
        check("rst_sum_out", bus.sum_out, 0);
        check("rst_term_count", SUM_W'(bus.term_count), 0);
        check("rst_count_err", SUM_W'(bus.count_err), 0);
        #2 rst_n = 1'b1;
        idle(2);

        // single term with cycle-exact latency
        do_start(DATA_W'(3));
        send_term(DATA_W'(5), 1'b1);
        check("t1_sum_valid_t2", SUM_W'(bus.sum_valid), 0);
        step();
        check("t1_sum_valid_t3", SUM_W'(bus.sum_valid), 1);
        check("t1_sum_out_lit", bus.sum_out, SUM_W'(8));
        wait_sum("t1");
        ack_sum();

        // full-scale terms
        full_term = '1;
        full_exp  = '0;
        full_exp[DATA_W+5] = 1'b1;
        full_exp  = full_exp - SUM_W'(31);
        do_start(DATA_W'(1));
        for (int i = 0; i < NUM_TERMS; i++) send_term(full_term, i == NUM_TERMS - 1);
        wait_sum("t2");
        check("t2_sum_out_lit", bus.sum_out, full_exp);
        ack_sum();

        // count overflow without term_last, then a 33rd term that must be refused
        do_start('0);
        for (int i = 0; i < NUM_TERMS; i++) send_term(DATA_W'(7), 1'b0);
        send_term(DATA_W'(7), 1'b0);
        wait_sum("t3");
        check("t3_sum_out_lit", bus.sum_out, SUM_W'(224));
        ack_sum();

        // gaps, then backpressure with an ignored start
        b4 = DATA_W'($urandom_range(0, 1000));
        do_start(b4);
        send_term(DATA_W'(1), 1'b0);
        idle(2);
        send_term(DATA_W'(2), 1'b0);
        idle(2);
        send_term(DATA_W'(3), 1'b1);
        wait_sum("t4");
        for (int i = 0; i < 10; i++) begin
            bus.start   = (i == 4);
            bus.base_in = DATA_W'(32'hdead);
            step();
            check("t4_hold_sum_valid", SUM_W'(bus.sum_valid), 1);
            check("t4_hold_sum_out", bus.sum_out, SUM_W'(b4) + SUM_W'(6));
            check("t4_hold_term_ready", SUM_W'(bus.term_ready), 0);
        end
        bus.start = 1'b0;

        // back-to-back: ack and start together
        bus.sum_ack = 1'b1;
        bus.start   = 1'b1;
        bus.base_in = DATA_W'(16);
        model_start(DATA_W'(16));
        step();
        bus.sum_ack = 1'b0;
        bus.start   = 1'b0;
        check("t5_term_ready", SUM_W'(bus.term_ready), 1);
        check("t5_sum_valid", SUM_W'(bus.sum_valid), 0);
        send_term(DATA_W'(1), 1'b1);
        wait_sum("t5");
        check("t5_sum_out_lit", bus.sum_out, SUM_W'(17));
        ack_sum();

        // randomized operations
        for (int op = 0; op < 8; op++) begin
            int n;
            logic no_last;
            n = $urandom_range(1, NUM_TERMS);
            no_last = (n == NUM_TERMS) && ($urandom_range(0, 1) == 1);
            do_start(rand_term());
            for (int i = 0; i < n; i++) begin
                send_term(rand_term(), (i == n - 1) && !no_last);
                idle($urandom_range(0, 2));
            end
            wait_sum("rand");
            idle($urandom_range(0, 3));
            ack_sum();
        end

        // asynchronous reset in the middle of an operation
        do_start(rand_term());
        for (int i = 0; i < 5; i++) send_term(DATA_W'($urandom_range(1, 100)), 1'b0);
        #2 rst_n = 1'b0;
        model_open = 1'b0;
        #1;
        check("t6_rst_term_ready", SUM_W'(bus.term_ready), 0);
        check("t6_rst_busy", SUM_W'(bus.busy), 0);
        check("t6_rst_sum_valid", SUM_W'(bus.sum_valid), 0);
        check("t6_rst_sum_out", bus.sum_out, 0);
        check("t6_rst_term_count", SUM_W'(bus.term_count), 0);
        check("t6_rst_count_err", SUM_W'(bus.count_err), 0);
        #1 rst_n = 1'b1;
        do_start('0);
        send_term(DATA_W'(2), 1'b1);
        wait_sum("t6");
        check("t6_sum_out_lit", bus.sum_out, SUM_W'(2));
        check("t6_term_count_lit", SUM_W'(bus.term_count), 1);
        ack_sum();

        check("scoreboard_drained", SUM_W'(exp_q.size()), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xpb_accum_seq.md
Name: xpb_accum_seq

Overview:
- Sequential reduction accumulator that sits directly downstream of the registered 5-bit→1024-bit XPB lookup tables in the modular-squaring datapath.
- Each operation loads a base value, which is the low (unreduced) part of the squared product.
- It then absorbs a stream of XPB table outputs, one per cycle, in carry-save form.
- After the last term it resolves the carry-save pair with one carry-propagate add and presents the widened sum to the next stage under a valid/ack handshake.

Parameters:
- DATA_W, 1024, width of base_in and of each XPB term.
- NUM_TERMS, 32, maximum terms per operation; also the count at which an operation is forced to end.
- CNT_W, 6, width of term_count; must satisfy 2^CNT_W > NUM_TERMS.
- SUM_W, DATA_W+6, width of sum_out; holds base plus NUM_TERMS full-scale terms.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins an operation; samples base_in.
- base_in  in  DATA_W  initial accumulator value.
- term_valid  in  1  term_in carries a valid XPB output. Arrives one cycle after the LUT index, because the LUT output is registered.
- term_in  in  DATA_W  XPB term.
- term_last  in  1  marks the final term; meaningful only when term_valid=1.
- term_ready  out  1  accumulator accepts a term this cycle.
- busy  out  1  an operation is in progress (any state other than IDLE).
- sum_valid  out  1  sum_out is valid.
- sum_out  out  SUM_W  resolved sum, base + Σterms.
- sum_ack  in  1  consumer takes sum_out.
- term_count  out  CNT_W  number of terms accepted in the current or last operation.
- count_err  out  1  sticky per operation: NUM_TERMS terms were accepted without term_last.

Behaviour:

Reset (rst_n=0, asynchronous):
- State goes to IDLE.
- Carry-save regs S and C, sum_out and term_count clear to 0.
- term_ready, busy, sum_valid and count_err clear to 0.
- Asserting reset mid-operation discards all work. There is no output activity until a new start.

States:
- IDLE:
  - term_ready=0.
  - On start: S←zero-extended base_in, C←0, term_count←0, count_err←0, go to ACCUM.
- ACCUM:
  - term_ready=1.
  - A term is accepted when term_valid=1: S←S^C^T and C←majority(S,C,T)<<1, all at SUM_W bits, where T is the zero-extended term_in. term_count increments.
  - If term_last=1, or the accepted term makes term_count==NUM_TERMS, go to RESOLVE.
  - In the second case without term_last, set count_err=1.
  - Cycles with term_valid=0 leave all state unchanged (gaps are allowed).
  - start is ignored.
- RESOLVE:
  - term_ready=0.
  - sum_out←S+C (SUM_W-bit add; no carry out can occur by construction).
  - Go to DONE.
- DONE:
  - sum_valid=1; sum_out, term_count and count_err are held stable.
  - On sum_ack: sum_valid falls next cycle and the state goes to IDLE.
  - If start is high in the same cycle as sum_ack, load base_in and go directly to ACCUM (back-to-back operations).
  - start without sum_ack is ignored.

Latency:
- start at cycle t → term_ready=1 at t+1.
- Last term accepted at cycle T → RESOLVE at T+1 → sum_valid=1 at T+2.
- Minimum 1-term operation: start→sum_valid is 3 cycles.

Other rules:
- term_valid or term_last while term_ready=0 is ignored; nothing is accepted.
- Every operation carries at least one term. There is no empty-operation path.
- Unused high bits of S, C and sum_out are kept zero-extended; arithmetic is unsigned, modulo 2^SUM_W.

Test Plan:
1. Single term: reset, start with base_in=0x3. Next cycle send term_in=0x5 with term_valid=1, term_last=1. Required: sum_valid at +2 cycles, sum_out=0x8, term_count=1, count_err=0.
2. Full-scale accumulation: base_in=1, then 32 terms of 2^1024−1, term_last on the 32nd. Required: sum_out=32·2^1024−31, term_count=32, count_err=0.
3. Count overflow: base_in=0, send 32 terms of value 7, all with term_last=0. Required: RESOLVE is entered automatically, sum_out=224, count_err=1. A 33rd term_valid is ignored (term_ready=0).
4. Gaps and backpressure:
   - Send terms 1, 2, 3 with term_valid low for 2 cycles between each; sum_out must be base+6.
   - Hold sum_ack=0 for 10 cycles: sum_valid and sum_out stay stable, term_ready=0, and a start pulse is ignored.
5. Back-to-back: in DONE, assert sum_ack and start together with base_in=0x10. Required: next cycle is ACCUM with term_ready=1; a following single term 0x1 yields sum_out=0x11.
6. Reset mid-operation: after 5 terms are accepted, pulse rst_n low asynchronously between edges. Required: immediate clear of all outputs. A fresh start with base_in=0 and term 0x2 gives sum_out=0x2, term_count=1.
